debug_cmd_ctrl: RTL

Abstract-command sequencer between the debug module's command register file and the core's debug port. It accepts one halt, resume or register-access command at a time. For each command it drives the core-side `pipdebug_interface` master port through the required handshake. It returns read data and a RISC-V-style `cmderr` code. It sits in the debug unit, directly in front of the core's `pipdebug_interface.slave` end.

---
 rtl/debug_pkg.sv | 46 ++++
 rtl/pipdebug_interface.sv | 37 +++
 rtl/debug_regno_decode.sv | 34 +++
 rtl/debug_cmd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug command path: command and error encodings,
// sequencer states and the abstract register number map.
`ifndef XLEN
`define XLEN 64
`endif

package debug_pkg;

  typedef enum logic [1:0] {
    CMD_HALT   = 2'b00,
    CMD_RESUME = 2'b01,
    CMD_ACCESS = 2'b10,
    CMD_RSVD   = 2'b11
  } dbg_cmd_e;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    NOTSUP     = 3'd2,
    EXCEPT     = 3'd3,
    HALTRESUME = 3'd4
  } dbg_cmderr_e;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    RESUME_WAIT,
    ACCESS,
    CAPTURE,
    RESP
  } dbg_state_e;

  typedef enum logic [1:0] {
    SEL_CSR,
    SEL_GPR,
    SEL_FPR,
    SEL_INV
  } dbg_sel_e;

  localparam logic [15:0] REGNO_CSR_BASE = 16'h0000;
  localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;
  localparam logic [15:0] REGNO_FPR_BASE = 16'h1020;
  localparam logic [15:0] REGNO_CSR_NUM  = 16'h1000;
  localparam logic [15:0] REGNO_GPR_NUM  = 16'h0020;
  localparam logic [15:0] REGNO_FPR_NUM  = 16'h0020;

endpackage

// File: rtl/pipdebug_interface.sv
// Core debug port: run control handshake plus CSR/GPR/FPR index, write and read-back buses.
interface pipdebug_interface #(
  parameter int XLEN = 64
);
  logic            haltreq;
  logic            resumereq;
  logic            halted;
  logic            run;
  logic [11:0]     csrindex;
  logic [XLEN-1:0] csrwdata;
  logic            csrwr;
  logic [XLEN-1:0] csrrdata;
  logic [4:0]      igprindex;
  logic [XLEN-1:0] igprwdata;
  logic            igprwr;
  logic [XLEN-1:0] igprrdata;
  logic [4:0]      fgprindex;
  logic [XLEN-1:0] fgprwdata;
  logic            fgprwr;
  logic [XLEN-1:0] fgprrdata;

  modport master (
    output haltreq, resumereq,
    output csrindex, csrwdata, csrwr,
    output igprindex, igprwdata, igprwr,
    output fgprindex, fgprwdata, fgprwr,
    input  halted, run, csrrdata, igprrdata, fgprrdata
  );

  modport slave (
    input  haltreq, resumereq,
    input  csrindex, csrwdata, csrwr,
    input  igprindex, igprwdata, igprwr,
    input  fgprindex, fgprwdata, fgprwr,
    output halted, run, csrrdata, igprrdata, fgprrdata
  );
endinterface

// File: rtl/debug_regno_decode.sv
// Maps an abstract register number onto the CSR, GPR or FPR file plus the index
// within that file; anything outside the three windows is flagged invalid.
module debug_regno_decode
  import debug_pkg::*;
(
  input  logic [15:0] regno_i,
  output logic [1:0]  sel_o,
  output logic [11:0] index_o
);

  logic [15:0] off_csr;
  logic [15:0] off_gpr;
  logic [15:0] off_fpr;

  assign off_csr = regno_i - REGNO_CSR_BASE;
  assign off_gpr = regno_i - REGNO_GPR_BASE;
  assign off_fpr = regno_i - REGNO_FPR_BASE;

  always_comb begin
    sel_o   = SEL_INV;
    index_o = 12'd0;
    if (off_csr < REGNO_CSR_NUM) begin
      sel_o   = SEL_CSR;
      index_o = off_csr[11:0];
    end else if (off_gpr < REGNO_GPR_NUM) begin
      sel_o   = SEL_GPR;
      index_o = {7'd0, off_gpr[4:0]};
    end else if (off_fpr < REGNO_FPR_NUM) begin
      sel_o   = SEL_FPR;
      index_o = {7'd0, off_fpr[4:0]};
    end
  end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Abstract-command sequencer: runs one halt, resume or register access at a time
// against the core debug port and returns read data with a cmderr code.
module debug_cmd_ctrl
  import debug_pkg::*;
#(
  parameter int XLEN         = `XLEN,
  parameter int HALT_TIMEOUT = 1023
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_type_i,
  input  logic                   cmd_write_i,
  input  logic [15:0]            cmd_regno_i,
  input  logic [XLEN-1:0]        cmd_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [XLEN-1:0]        rsp_rdata_o,
  output logic [2:0]             rsp_err_o,
  output logic                   busy_o,
  pipdebug_interface.master      dbg
);

  localparam int CNT_W = ($clog2(HALT_TIMEOUT + 1) > 10) ? $clog2(HALT_TIMEOUT + 1) : 10;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HALT_TIMEOUT);

  dbg_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbg_sel_e        sel_q, sel_d;
  logic            write_q, write_d;
  logic            x0_q, x0_d;
  logic            haltreq_q, haltreq_d;
  logic            resumereq_q, resumereq_d;
  logic [11:0]     csrindex_q, csrindex_d;
  logic [XLEN-1:0] csrwdata_q, csrwdata_d;
  logic            csrwr_q, csrwr_d;
  logic [4:0]      igprindex_q, igprindex_d;
  logic [XLEN-1:0] igprwdata_q, igprwdata_d;
  logic            igprwr_q, igprwr_d;
  logic [4:0]      fgprindex_q, fgprindex_d;
  logic [XLEN-1:0] fgprwdata_q, fgprwdata_d;
  logic            fgprwr_q, fgprwr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  dbg_cmderr_e     rsp_err_q, rsp_err_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;

  logic [1:0]      dec_sel;
  logic [11:0]     dec_index;
  dbg_sel_e        dec_sel_e;

  debug_regno_decode u_decode (
    .regno_i (cmd_regno_i),
    .sel_o   (dec_sel),
    .index_o (dec_index)
  );

  assign dec_sel_e = dbg_sel_e'(dec_sel);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    write_d     = write_q;
    x0_d        = x0_q;
    haltreq_d   = 1'b0;
    resumereq_d = 1'b0;
    csrindex_d  = csrindex_q;
    csrwdata_d  = csrwdata_q;
    csrwr_d     = 1'b0;
    igprindex_d = igprindex_q;
    igprwdata_d = igprwdata_q;
    igprwr_d    = 1'b0;
    fgprindex_d = fgprindex_q;
    fgprwdata_d = fgprwdata_q;
    fgprwr_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          write_d     = cmd_write_i;
          sel_d       = dec_sel_e;
          x0_d        = (dec_sel_e == SEL_GPR) && (dec_index[4:0] == 5'd0);
          rsp_rdata_d = '0;
          rsp_err_d   = NONE;
          case (dbg_cmd_e'(cmd_type_i))
            CMD_HALT: begin
              if (dbg.halted) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
              end else begin
                state_d   = HALT_WAIT;
                cnt_d     = '0;
                haltreq_d = 1'b1;
              end
            end
            CMD_RESUME: begin
              if (!dbg.halted) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = HALTRESUME;
              end else begin
                state_d     = RESUME_WAIT;
                cnt_d       = '0;
                resumereq_d = 1'b1;
              end
            end
            CMD_ACCESS: begin
              if (!dbg.halted) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = HALTRESUME;
              end else if (dec_sel_e == SEL_INV) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = NOTSUP;
              end else begin
                state_d = ACCESS;
                // The write strobe is registered here so it is high for the ACCESS cycle only.
                case (dec_sel_e)
                  SEL_CSR: begin
                    csrindex_d = dec_index;
                    csrwdata_d = cmd_wdata_i;
                    csrwr_d    = cmd_write_i;
                  end
                  SEL_GPR: begin
                    igprindex_d = dec_index[4:0];
                    igprwdata_d = cmd_wdata_i;
                    igprwr_d    = cmd_write_i && (dec_index[4:0] != 5'd0);
                  end
                  SEL_FPR: begin
                    fgprindex_d = dec_index[4:0];
                    fgprwdata_d = cmd_wdata_i;
                    fgprwr_d    = cmd_write_i;
                  end
                  default: ;
                endcase
              end
            end
            default: begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = NOTSUP;
            end
          endcase
        end
      end
      HALT_WAIT: begin
        // A halt seen on the same cycle the counter expires still counts as success.
        if (dbg.halted) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = NONE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = EXCEPT;
        end else begin
          haltreq_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESUME_WAIT: begin
        if (dbg.run) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = NONE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = EXCEPT;
        end else begin
          resumereq_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        case (sel_q)
          SEL_CSR: rsp_rdata_d = dbg.csrrdata;
          SEL_GPR: rsp_rdata_d = dbg.igprrdata;
          SEL_FPR: rsp_rdata_d = dbg.fgprrdata;
          default: rsp_rdata_d = '0;
        endcase
        if (write_q || x0_q) rsp_rdata_d = '0;
        csrindex_d  = '0;
        csrwdata_d  = '0;
        igprindex_d = '0;
        igprwdata_d = '0;
        fgprindex_d = '0;
        fgprwdata_d = '0;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = NONE;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= SEL_CSR;
      write_q     <= 1'b0;
      x0_q        <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      csrindex_q  <= '0;
      csrwdata_q  <= '0;
      csrwr_q     <= 1'b0;
      igprindex_q <= '0;
      igprwdata_q <= '0;
      igprwr_q    <= 1'b0;
      fgprindex_q <= '0;
      fgprwdata_q <= '0;
      fgprwr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= NONE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      write_q     <= write_d;
      x0_q        <= x0_d;
      haltreq_q   <= haltreq_d;
      resumereq_q <= resumereq_d;
      csrindex_q  <= csrindex_d;
      csrwdata_q  <= csrwdata_d;
      csrwr_q     <= csrwr_d;
      igprindex_q <= igprindex_d;
      igprwdata_q <= igprwdata_d;
      igprwr_q    <= igprwr_d;
      fgprindex_q <= fgprindex_d;
      fgprwdata_q <= fgprwdata_d;
      fgprwr_q    <= fgprwr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign dbg.haltreq   = haltreq_q;
  assign dbg.resumereq = resumereq_q;
  assign dbg.csrindex  = csrindex_q;
  assign dbg.csrwdata  = csrwdata_q;
  assign dbg.csrwr     = csrwr_q;
  assign dbg.igprindex = igprindex_q;
  assign dbg.igprwdata = igprwdata_q;
  assign dbg.igprwr    = igprwr_q;
  assign dbg.fgprindex = fgprindex_q;
  assign dbg.fgprwdata = fgprwdata_q;
  assign dbg.fgprwr    = fgprwr_q;

endmodule
